// File: rtl/par_gen_pkg.sv
// Shared constants and helpers for the par_gen parity generator.
//   EVEN / ODD  : parity-sense selectors for the par_xor3 'odd' input.
//   ERR_CNT_W   : width of the saturating mismatch counter.
//   parity3()   : XOR reduction of three bits (even-parity bit).
package par_gen_pkg;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;

  // Even-parity bit over three inputs; invert externally for odd parity.
  function automatic logic parity3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/par_xor3.sv
// Combinational parity / population-count leaf for par_gen.
// Ports:
//   a, b, c  in   data triple, a is the MSB
//   odd      in   1 selects odd parity, 0 selects even parity
//   par      out  parity bit over {a,b,c} in the selected sense
//   ones     out  number of set bits in {a,b,c}, 0..3
module par_xor3
  import par_gen_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       odd,
  output logic       par,
  output logic [1:0] ones
);

  always_comb begin
    par  = parity3(a, b, c) ^ odd;
    ones = {1'b0, a} + {1'b0, b} + {1'b0, c};
  end

endmodule

// File: rtl/par_gen.sv
// Registered 3-input parity generator with ones count, one-cycle latency.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears all outputs
//   a, b, c    in   data triple (a is the MSB), sampled when in_valid=1
//   in_valid   in   qualifies a/b/c on this cycle
//   pout       out  registered parity bit (even unless ODD_PARITY=1)
//   ones       out  registered count of ones in the last sampled triple
//   out_valid  out  pout/ones belong to the triple sampled on the previous edge
// Optional (macro PAR_GEN_CHECK_EN defined):
//   p_in       in   received parity bit to compare against the computed one
//   err        out  registered mismatch flag, aligned with out_valid
//   err_cnt    out  saturating mismatch counter
module par_gen
  import par_gen_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 in_valid,
`ifdef PAR_GEN_CHECK_EN
  input  logic                 p_in,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic                 pout,
  output logic [1:0]           ones,
  output logic                 out_valid
);

  logic       par;
  logic [1:0] ones_cnt;

  par_xor3 u_par_xor3 (
    .a    (a),
    .b    (b),
    .c    (c),
    .odd  (ODD_PARITY ? ODD : EVEN),
    .par  (par),
    .ones (ones_cnt)
  );

  logic       pout_d, pout_q;
  logic [1:0] ones_d, ones_q;
  logic       valid_d, valid_q;

  // Data registers load only on a valid sample, so X on a/b/c while idle never
  // reaches the outputs.
  always_comb begin
    pout_d  = pout_q;
    ones_d  = ones_q;
    valid_d = in_valid;
    if (in_valid) begin
      pout_d = par;
      ones_d = ones_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout_q  <= 1'b0;
      ones_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      pout_q  <= pout_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
    end
  end

  assign pout      = pout_q;
  assign ones      = ones_q;
  assign out_valid = valid_q;

`ifdef PAR_GEN_CHECK_EN
  logic                 err_d, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  // err is a per-sample flag (cleared on idle cycles); err_cnt accumulates and
  // sticks at all-ones.
  always_comb begin
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (in_valid) begin
      err_d = (p_in != par);
      if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_par_gen.sv
// Self-checking bench for par_gen: an even-parity and an odd-parity instance
// share one stimulus stream; expectations come from a ones-count model.
module tb_par_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, in_valid, p_in;

  logic       pout_e, pout_o, ov_e, ov_o;
  logic [1:0] ones_e, ones_o;
`ifdef PAR_GEN_CHECK_EN
  logic       err_e, err_o;
  logic [7:0] cnt_e, cnt_o;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic exp_pe, exp_po, exp_ov;
  int   exp_ones;
  logic exp_err_e, exp_err_o;
  int   exp_cnt_e, exp_cnt_o;

  always #5 clk = ~clk;

  par_gen #(.ODD_PARITY(1'b0)) dut_even (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
`ifdef PAR_GEN_CHECK_EN
    .p_in      (p_in),
    .err       (err_e),
    .err_cnt   (cnt_e),
`endif
    .pout      (pout_e),
    .ones      (ones_e),
    .out_valid (ov_e)
  );

  par_gen #(.ODD_PARITY(1'b1)) dut_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
`ifdef PAR_GEN_CHECK_EN
    .p_in      (p_in),
    .err       (err_o),
    .err_cnt   (cnt_o),
`endif
    .pout      (pout_o),
    .ones      (ones_o),
    .out_valid (ov_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pout_even"}, {7'd0, pout_e}, {7'd0, exp_pe});
    check({tag, ".pout_odd"},  {7'd0, pout_o}, {7'd0, exp_po});
    check({tag, ".ones_even"}, {6'd0, ones_e}, 8'(exp_ones));
    check({tag, ".ones_odd"},  {6'd0, ones_o}, 8'(exp_ones));
    check({tag, ".ov_even"},   {7'd0, ov_e},   {7'd0, exp_ov});
    check({tag, ".ov_odd"},    {7'd0, ov_o},   {7'd0, exp_ov});
`ifdef PAR_GEN_CHECK_EN
    check({tag, ".err_even"},  {7'd0, err_e},  {7'd0, exp_err_e});
    check({tag, ".err_odd"},   {7'd0, err_o},  {7'd0, exp_err_o});
    check({tag, ".cnt_even"},  cnt_e,          8'(exp_cnt_e));
    check({tag, ".cnt_odd"},   cnt_o,          8'(exp_cnt_o));
`endif
  endtask

  task automatic model_clear();
    exp_pe    = 1'b0;
    exp_po    = 1'b0;
    exp_ov    = 1'b0;
    exp_ones  = 0;
    exp_err_e = 1'b0;
    exp_err_o = 1'b0;
    exp_cnt_e = 0;
    exp_cnt_o = 0;
  endtask

  // Drive one cycle of stimulus, update the model across the edge, settle 1ns.
  task automatic step(input logic ia, input logic ib, input logic ic, input logic iv,
                      input logic ip);
    int cnt;
    @(negedge clk);
    a = ia; b = ib; c = ic; in_valid = iv; p_in = ip;
    @(posedge clk);
    exp_ov = iv;
    if (iv) begin
      cnt      = (ia ? 1 : 0) + (ib ? 1 : 0) + (ic ? 1 : 0);
      exp_ones = cnt;
      exp_pe   = (cnt % 2) == 1;
      exp_po   = (cnt % 2) == 0;
      exp_err_e = (ip != exp_pe);
      exp_err_o = (ip != exp_po);
      if (exp_err_e && exp_cnt_e < 255) exp_cnt_e++;
      if (exp_err_o && exp_cnt_o < 255) exp_cnt_o++;
    end else begin
      exp_err_e = 1'b0;
      exp_err_o = 1'b0;
    end
    #1;
  endtask

  // Assert reset mid-cycle, check clear without any clock edge, release on a negedge.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] v;
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; in_valid = 1'b0; p_in = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("por");

    // T1: load non-zero outputs, then async reset with no clock edge
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_all("pre_rst");
    reset_mid("t1_rst");

    // T2/T3: full sweep, back-to-back valids
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      step(v[2], v[1], v[0], 1'b1, 1'b0);
      check_all($sformatf("t2_sweep%0d", i));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check({"t3_000.pout_odd"}, {7'd0, pout_o}, 8'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check({"t3_111.pout_odd"}, {7'd0, pout_o}, 8'd0);

    // T4: hold with X on the data inputs while idle
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_all("t4_load");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("t4_hold");
    step(1'bx, 1'bx, 1'bx, 1'b0, 1'bx);
    check_all("t4_hold_x");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom));
      check_all($sformatf("rnd%0d", i));
    end

`ifdef PAR_GEN_CHECK_EN
    // T5: checker behaviour from a clean counter
    reset_mid("t5_rst");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_all("t5_mis");
    check("t5_mis.cnt_abs", cnt_e, 8'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("t5_match");
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_all("t5_sat");
    check("t5_sat.cnt_abs", cnt_e, 8'hff);
`endif

    // T6: reset during back-to-back valids, then first post-reset valid
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("t6_stream");
    reset_mid("t6_rst");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("t6_first");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_all("t6_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
